// File: rtl/rvv_backend_alu_issue_ctrl_pkg.sv
// Shared types for the RVV ALU issue controller: slot and controller FSM
// states plus a modular-add helper for the rotating unit pointer.
package rvv_backend_alu_issue_ctrl_pkg;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} ALU_ISSUE_SLOT_e;
  typedef enum logic {ISS_RUN = 1'b0, ISS_FLUSH = 1'b1} ALU_ISSUE_FSM_e;

  // (a + b) mod n for a < n and b <= n; a single conditional subtract suffices,
  // so n does not have to be a power of two.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rvv_backend_alu_issue_slot.sv
// One per-unit issue register with its EMPTY/FULL state; holds the uop stable
// until the unit accepts it, and drops it on flush.
module rvv_backend_alu_issue_slot
  import rvv_backend_alu_issue_ctrl_pkg::*;
#(
  parameter int UOP_W = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [UOP_W-1:0] load_uop,
  input  logic             ready,
  input  logic             flush,
  output logic             valid,
  output logic [UOP_W-1:0] uop
);

  ALU_ISSUE_SLOT_e state;

  // NOTE: the payload is reset too, because the unit-facing uop bus must read
  // as zero after reset; it is not cleared on flush since valid already drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      uop   <= '0;
    end else if (flush) begin
      state <= SLOT_EMPTY;
    end else if (load) begin
      state <= SLOT_FULL;
      uop   <= load_uop;
    end else if (ready) begin
      state <= SLOT_EMPTY;
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/rvv_backend_alu_issue_ctrl.sv
// In-order ALU issue scheduler: pops the longest issuable prefix of the RS head
// window into rotating per-unit issue registers. Perf counters under RVV_ALU_ISSUE_PERF_EN.
module rvv_backend_alu_issue_ctrl
  import rvv_backend_alu_issue_ctrl_pkg::*;
#(
  parameter int NUM_ALU = 2,
  parameter int UOP_W   = 160,
  parameter int PTR_W   = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1,
  parameter int PERF_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ALU-1:0]       uop_valid_rs2ctl,
  input  logic [NUM_ALU*UOP_W-1:0] uop_rs2ctl,
  output logic [NUM_ALU-1:0]       pop_ctl2rs,
  output logic [NUM_ALU-1:0]       unit_valid_ctl2alu,
  output logic [NUM_ALU*UOP_W-1:0] unit_uop_ctl2alu,
  input  logic [NUM_ALU-1:0]       unit_ready_alu2ctl,
  input  logic                     trap_flush_rvv,
  output logic                     ctl_busy,
  output logic [PERF_W-1:0]        perf_issue_cnt,
  output logic [PERF_W-1:0]        perf_stall_cnt
);

  localparam int CNT_W = PTR_W + 1;

  ALU_ISSUE_FSM_e     fsm;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_ALU-1:0] slot_valid, free, load, pop;
  logic [UOP_W-1:0]   load_uop [NUM_ALU];
  logic [CNT_W-1:0]   pop_cnt;
  logic               flush_any;

  assign flush_any = trap_flush_rvv | (fsm == ISS_FLUSH);
  assign free      = ~slot_valid | unit_ready_alu2ctl;

  // NOTE: block-local temporaries in always_comb use blocking '=' and are
  // assigned before use on every path, so no latch is inferred.
  always_comb begin
    int   t;
    logic go;
    logic tgt_free;
    pop     = '0;
    load    = '0;
    pop_cnt = '0;
    go      = ~rst & (fsm == ISS_RUN) & ~trap_flush_rvv;
    for (int u = 0; u < NUM_ALU; u++) load_uop[u] = '0;
    for (int j = 0; j < NUM_ALU; j++) begin
      t        = wrap_add(int'(ptr), j, NUM_ALU);
      tgt_free = 1'b0;
      for (int u = 0; u < NUM_ALU; u++) if (u == t) tgt_free = free[u];
      // The first entry that cannot go blocks every younger one.
      if (go && uop_valid_rs2ctl[j] && tgt_free) begin
        pop[j]  = 1'b1;
        pop_cnt = pop_cnt + CNT_W'(1);
        for (int u = 0; u < NUM_ALU; u++) begin
          if (u == t) begin
            load[u]     = 1'b1;
            load_uop[u] = uop_rs2ctl[j*UOP_W +: UOP_W];
          end
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= ISS_RUN;
      ptr <= '0;
    end else begin
      fsm <= trap_flush_rvv ? ISS_FLUSH : ISS_RUN;
      ptr <= flush_any ? '0 : PTR_W'(wrap_add(int'(ptr), int'(pop_cnt), NUM_ALU));
    end
  end

  for (genvar u = 0; u < NUM_ALU; u++) begin : g_slot
    rvv_backend_alu_issue_slot #(.UOP_W(UOP_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[u]),
      .load_uop (load_uop[u]),
      .ready    (unit_ready_alu2ctl[u]),
      .flush    (flush_any),
      .valid    (slot_valid[u]),
      .uop      (unit_uop_ctl2alu[u*UOP_W +: UOP_W])
    );
  end

  assign pop_ctl2rs         = pop;
  assign unit_valid_ctl2alu = slot_valid;
  assign ctl_busy           = (|slot_valid) | (fsm == ISS_FLUSH);

`ifdef RVV_ALU_ISSUE_PERF_EN
  logic [PERF_W-1:0] issue_cnt, stall_cnt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [PERF_W:0]   issue_sum;

  always_comb begin
    acc_cnt = '0;
    for (int u = 0; u < NUM_ALU; u++)
      if (slot_valid[u] && unit_ready_alu2ctl[u]) acc_cnt = acc_cnt + CNT_W'(1);
  end

  assign issue_sum = {1'b0, issue_cnt} + (PERF_W+1)'(acc_cnt);

  // Both counters saturate and survive flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      issue_cnt <= issue_sum[PERF_W] ? '1 : issue_sum[PERF_W-1:0];
      if (uop_valid_rs2ctl[0] && (pop == '0) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign perf_issue_cnt = issue_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

  a_valid_thermo: assert property (@(posedge clk) disable iff (rst)
    ((uop_valid_rs2ctl >> 1) & ~uop_valid_rs2ctl) == '0);

  a_pop_subset: assert property (@(posedge clk) disable iff (rst)
    (pop_ctl2rs & ~uop_valid_rs2ctl) == '0);

endmodule

// File: doc/rvv_backend_alu_issue_ctrl.md
Name: rvv_backend_alu_issue_ctrl

Overview:
- In-order issue scheduler between the ALU reservation-station FIFO head window and the `NUM_ALU` ALU units.
- Each cycle it takes the longest issuable prefix of the head window and pops that prefix from the RS.
- Each popped uop is placed in a per-unit issue register. Units are assigned by a rotating pointer, which spreads load evenly.
- Holds uops until each unit accepts them with a valid/ready handshake, and discards everything on trap flush.

Parameters:
- NUM_ALU, 2, number of ALU units and RS head-window entries (1..4).
- UOP_W, 160, width of one flattened ALU_RS_t uop.
- PTR_W, $clog2(NUM_ALU) (min 1), width of the rotation pointer.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- uop_valid_rs2ctl  in  NUM_ALU  head-window valids; thermometer (bit j set implies bits <j set).
- uop_rs2ctl  in  NUM_ALU*UOP_W  head-window uops; entry 0 is the oldest.
- pop_ctl2rs  out  NUM_ALU  pops the window prefix; always thermometer.
- unit_valid_ctl2alu  out  NUM_ALU  issue-register valid per unit.
- unit_uop_ctl2alu  out  NUM_ALU*UOP_W  issue-register uop per unit.
- unit_ready_alu2ctl  in  NUM_ALU  unit accepts its uop this cycle.
- trap_flush_rvv  in  1  discard all uops not yet accepted.
- ctl_busy  out  1  any issue register FULL, or FSM in FLUSH.
- perf_issue_cnt  out  PERF_W  uops accepted by units (optional feature).
- perf_stall_cnt  out  PERF_W  cycles with window entry 0 valid but pop_ctl2rs==0 (optional feature).

Behaviour:
- Reset (rst=1 at posedge):
  - ptr=0; all slots EMPTY; FSM=RUN.
  - unit_valid_ctl2alu=0, unit_uop_ctl2alu=0, pop_ctl2rs=0, ctl_busy=0, perf counters=0.
  - rst overrides flush and any in-progress handshake.
- Slot FSM, per unit u:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on accept (valid&ready) with no load.
  - FULL -> FULL on accept plus load in the same cycle (back-to-back issue).
  - FULL with ready=0 holds; the uop stays stable.
- Slot free next cycle: free[u] = EMPTY | unit_ready_alu2ctl[u].
- Target mapping: window entry j targets unit t(j) = (ptr + j) mod NUM_ALU.
- Pop rule (combinational):
  - pop[j] = RUN & !trap_flush_rvv & uop_valid_rs2ctl[j] & free[t(j)] & pop[j-1]; pop[-1]=1.
  - The first blocked entry blocks all younger entries; strict program order.
- Load: the popped entry j is written into slot t(j) at the next posedge. The unit sees it one cycle after the pop (latency 1).
- Pointer: ptr <= (ptr + popcount(pop)) mod NUM_ALU. Wrap-around is by modular add; NUM_ALU need not be a power of 2.
- Controller FSM:
  - RUN -> FLUSH when trap_flush_rvv=1.
  - FLUSH -> RUN the cycle after trap_flush_rvv deasserts.
  - On the trap_flush_rvv cycle and throughout FLUSH: all slots forced EMPTY, ptr=0, pop_ctl2rs=0.
- Accept during flush: an accept in the same cycle as trap_flush_rvv still counts as accepted by the unit. The controller drops its copy.
- Input protocol: a non-thermometer uop_valid_rs2ctl is illegal; covered by an SVA.
- Output invariant: pop_ctl2rs ⊆ uop_valid_rs2ctl, checked by SVA.
- Empty window: no pops and ptr unchanged. Slots drain normally.
- All units stalled: pop_ctl2rs=0 and the window is retained by the RS.

Optional Feature:
- Macro: RVV_ALU_ISSUE_PERF_EN.
- Defined:
  - perf_issue_cnt increments by popcount(unit_valid & unit_ready) each cycle.
  - perf_stall_cnt increments on stall cycles.
  - Both saturate at all-ones and clear on rst only, not on flush.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared rvv_backend package (rvv_backend.svh):
  - ALU_ISSUE_SLOT_e {SLOT_EMPTY, SLOT_FULL}.
  - ALU_ISSUE_FSM_e {ISS_RUN, ISS_FLUSH}.
  - Uses the existing `NUM_ALU / ALU_RS_t definitions.
- Sub-module rvv_backend_alu_issue_slot: one issue register plus its EMPTY/FULL FSM (load, accept, flush inputs; valid and uop outputs). Instantiated NUM_ALU times.

Test Plan:
- Steady-state rotation:
  - Stimulus: NUM_ALU=2, ready=2'b11, window valid=2'b11 every cycle.
  - Response: pop=2'b11 every cycle, ptr stays 0, each unit gets one uop per cycle, order A->u0, B->u1.
- Partial issue with wrap:
  - Stimulus: ptr=1, window valid=2'b11, unit0 FULL with ready=0, unit1 free.
  - Response: pop=2'b01, entry0->u1, ptr wraps to 0. The next cycle retries the old entry1 against u0.
- In-order blocking:
  - Stimulus: ptr=0, u0 FULL with ready=0, u1 free, valid=2'b11.
  - Response: pop=2'b00 (entry1 not popped past a blocked entry0); perf_stall_cnt +1 with the macro defined.
- Back-to-back on one unit:
  - Stimulus: NUM_ALU=1, ready=1 constant, 4 uops.
  - Response: unit_valid high for 4 consecutive cycles starting 1 cycle after the first pop; uops arrive in order.
- Flush mid-stream:
  - Stimulus: both slots FULL with ready=0, trap_flush_rvv=1 for 2 cycles.
  - Response: pop=0 during flush and for 1 cycle after. unit_valid=0 from the cycle after the flush asserts. ptr=0, then normal issue resumes.
- Reset mid-operation:
  - Stimulus: rst=1 while slots are FULL and flush is asserted.
  - Response: next cycle, all outputs are 0, FSM=RUN, and the perf counters are cleared.
